// File: rtl/regfile_write_queue.sv
// -----------------------------------------------------------------------------
// regfile_write_queue
//
// Write-back buffer in front of a 32x32 register file. Register writes from
// the execute/write-back stage are queued in a small circular FIFO and drained
// one per cycle into the register file's single write port. Queued data that
// has not yet been committed is forwarded onto both read ports, so readers
// always see the architecturally newest value.
//
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   InValid/InReady               enqueue handshake (InReady = !full)
//   InRegister/InData             incoming write; register 0 is accepted
//                                 but dropped
//   Hold                          suspends draining
//   WriteRegister/WriteData/
//   RegWrite                      register file write port (head entry)
//   ReadRegister1/2               read addresses (shared with register file)
//   RegReadData1/2                raw register file read data
//   ReadData1/2                   forwarded read data
//   Count, Empty                  occupancy
// -----------------------------------------------------------------------------
module regfile_write_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [AW-1:0]          InRegister,
   input  logic [WIDTH-1:0]       InData,
   input  logic                   Hold,
   output logic [AW-1:0]          WriteRegister,
   output logic [WIDTH-1:0]       WriteData,
   output logic                   RegWrite,
   input  logic [AW-1:0]          ReadRegister1,
   input  logic [AW-1:0]          ReadRegister2,
   input  logic [WIDTH-1:0]       RegReadData1,
   input  logic [WIDTH-1:0]       RegReadData2,
   output logic [WIDTH-1:0]       ReadData1,
   output logic [WIDTH-1:0]       ReadData2,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [AW-1:0]    addr_d [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   // ---------------------------------------------------------------------------
   // Handshake and drain control
   // ---------------------------------------------------------------------------
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      InReady  = !full;
      Empty    = empty;
      Count    = count_q;
      RegWrite = !empty && !Hold && !Reset;
      pop      = RegWrite;
      // Writes to register 0 complete the handshake but are never stored.
      push     = InValid && InReady && !Reset && (InRegister != '0);
   end

   always_comb begin
      WriteRegister = '0;
      WriteData     = '0;
      if (!empty) begin
         WriteRegister = addr_q[head_q];
         WriteData     = data_q[head_q];
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state for pointers, occupancy and storage
   // ---------------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;

      if (push) begin
         addr_d[tail_q] = InRegister;
         data_d[tail_q] = InData;
         tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         addr_q  <= '{default: '0};
         data_q  <= '{default: '0};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read forwarding
   // ---------------------------------------------------------------------------
   // Scan occupied entries oldest to youngest; a later match overrides an
   // earlier one, so the entry closest to the tail wins. The head entry being
   // drained this cycle is still occupied and therefore still forwarded.
   function automatic logic [WIDTH-1:0] forward(input logic [AW-1:0]    rr,
                                                input logic [WIDTH-1:0] rf_data);
      logic [WIDTH-1:0] res;
      logic [PW-1:0]    idx;
      res = rf_data;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == rr)) begin
            res = data_q[idx];
         end
      end
      if (rr == '0) begin
         res = '0;
      end
      return res;
   endfunction

   always_comb begin
      ReadData1 = forward(ReadRegister1, RegReadData1);
      ReadData2 = forward(ReadRegister2, RegReadData2);
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;

   logic        clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRegister;
   logic [31:0] InData;
   logic        Hold;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] RegReadData1;
   logic [31:0] RegReadData2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [2:0]  Count;
   logic        Empty;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected commits, in order: {addr, data}
   logic [36:0] exp_q [$];

   // Stub register file. Entry 0 is deliberately nonzero so that the
   // forced-zero read of register 0 is observable.
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   regfile_write_queue #(
      .DEPTH (4),
      .WIDTH (32),
      .AW    (5)
   ) dut (
      .Clk           (clk),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InRegister    (InRegister),
      .InData        (InData),
      .Hold          (Hold),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .RegReadData1  (RegReadData1),
      .RegReadData2  (RegReadData2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .Count         (Count),
      .Empty         (Empty)
   );

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[0] = 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (RegWrite === 1'b1) rf[WriteRegister] <= WriteData;
   end

   assign RegReadData1 = rf[ReadRegister1];
   assign RegReadData2 = rf[ReadRegister2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write-port commit is compared against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got reg %0d data %0h expected no write at %0t",
                        WriteRegister, WriteData, $time);
            end else begin
               logic [36:0] e;
               e = exp_q.pop_front();
               check("commit_addr", {27'h0, WriteRegister}, {27'h0, e[36:32]});
               check("commit_data", WriteData, e[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic enq(input logic [4:0] a, input logic [31:0] d);
      InValid    = 1'b1;
      InRegister = a;
      InData     = d;
      for (int k = 0; k < 20 && !InReady; k++) step();
      if (!InReady) begin
         n_checks++;
         n_fail++;
         $display("FAIL enq_timeout: got InReady 0 expected 1 for reg %0d", a);
      end else if (a != 5'd0) begin
         exp_q.push_back({a, d});
      end
      step();
      InValid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; InValid = 1'b0; InRegister = '0; InData = '0; Hold = 1'b0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      step();
      step();
      check("regwrite_in_reset", {31'h0, RegWrite}, 32'd0);
      Reset = 1'b0;
      #1;
      check("reset_empty", {31'h0, Empty}, 32'd1);
      check("reset_inready", {31'h0, InReady}, 32'd1);
      check("reset_count", {29'h0, Count}, 32'd0);
      check("reset_wreg", {27'h0, WriteRegister}, 32'd0);
      check("reset_wdata", WriteData, 32'd0);

      // Single write: visible on the write port one cycle after acceptance
      enq(5'd5, 32'd9);
      check("t1_regwrite", {31'h0, RegWrite}, 32'd1);
      check("t1_count", {29'h0, Count}, 32'd1);
      ReadRegister1 = 5'd5;
      #1;
      check("t1_fwd_pending", ReadData1, 32'd9);
      step();
      ReadRegister2 = 5'd5;
      #1;
      check("t1_empty_after", {31'h0, Empty}, 32'd1);
      check("t1_rd1_from_rf", ReadData1, 32'd9);
      check("t1_rd2_from_rf", ReadData2, 32'd9);

      // Fill under Hold; youngest matching entry is forwarded
      Hold = 1'b1;
      enq(5'd2, 32'd22);
      enq(5'd3, 32'd23);
      enq(5'd2, 32'd44);
      enq(5'd4, 32'd7);
      ReadRegister1 = 5'd2;
      ReadRegister2 = 5'd3;
      #1;
      check("t2_count_full", {29'h0, Count}, 32'd4);
      check("t2_inready_full", {31'h0, InReady}, 32'd0);
      check("t2_regwrite_hold", {31'h0, RegWrite}, 32'd0);
      check("t2_fwd_youngest", ReadData1, 32'd44);
      check("t2_fwd_port2", ReadData2, 32'd23);
      InValid = 1'b1; InRegister = 5'd6; InData = 32'd1;
      step();
      step();
      check("t2_count_no_accept", {29'h0, Count}, 32'd4);
      InValid = 1'b0;

      // Release Hold: four back-to-back commits
      Hold = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("t3_regwrite_burst", {31'h0, RegWrite}, 32'd1);
         step();
      end
      check("t3_regwrite_done", {31'h0, RegWrite}, 32'd0);
      check("t3_empty", {31'h0, Empty}, 32'd1);
      ReadRegister1 = 5'd2; ReadRegister2 = 5'd3;
      #1;
      check("t3_reg2", ReadData1, 32'd44);
      check("t3_reg3", ReadData2, 32'd23);
      ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
      #1;
      check("t3_reg4", ReadData1, 32'd7);
      check("t3_reg6_unwritten", ReadData2, 32'd0);

      // Register 0 write: accepted, dropped; register 0 reads as zero
      check("t4_inready", {31'h0, InReady}, 32'd1);
      enq(5'd0, 32'd22);
      ReadRegister1 = 5'd0;
      #1;
      check("t4_count", {29'h0, Count}, 32'd0);
      check("t4_regwrite", {31'h0, RegWrite}, 32'd0);
      check("t4_rd_zero", ReadData1, 32'd0);
      step();

      // Full queue, drain with InValid held; pointers wrap
      Hold = 1'b1;
      enq(5'd10, 32'd100);
      enq(5'd11, 32'd101);
      enq(5'd12, 32'd102);
      enq(5'd13, 32'd103);
      Hold = 1'b0;
      InValid = 1'b1; InRegister = 5'd8; InData = 32'd88;
      #1;
      check("t5_inready_full", {31'h0, InReady}, 32'd0);
      check("t5_count_full", {29'h0, Count}, 32'd4);
      step();
      for (int k = 0; k < 5; k++) begin
         check("t5_inready_stream", {31'h0, InReady}, 32'd1);
         check("t5_count_stream", {29'h0, Count}, 32'd3);
         exp_q.push_back({5'd8, 32'd88});
         step();
      end
      InValid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("t5_drained", {31'h0, Empty}, 32'd1);

      // Reset with pending entries: nothing commits
      Hold = 1'b1;
      enq(5'd20, 32'd200);
      enq(5'd21, 32'd201);
      enq(5'd22, 32'd202);
      check("t6_count_pre", {29'h0, Count}, 32'd3);
      exp_q.delete();
      Reset = 1'b1;
      Hold  = 1'b0;
      #1;
      check("t6_regwrite_reset", {31'h0, RegWrite}, 32'd0);
      step();
      Reset = 1'b0;
      ReadRegister1 = 5'd20; ReadRegister2 = 5'd22;
      #1;
      check("t6_count_post", {29'h0, Count}, 32'd0);
      check("t6_empty_post", {31'h0, Empty}, 32'd1);
      check("t6_regwrite_post", {31'h0, RegWrite}, 32'd0);
      check("t6_reg20", ReadData1, 32'd0);
      check("t6_reg22", ReadData2, 32'd0);
      step();
      step();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
